// File: rtl/cache_bus_arbiter.sv
// Purpose: merges I-cache and D-cache SRAM-like miss requests onto one bridge port, one transaction in flight.
// Latency: request-to-bus_req 1 cycle; grant phase passes the winner's request straight through to the bus.
// Backpressure: winner is held in ADDR until bus_addr_ok, then in DATA until bus_data_ok; the loser waits.
// Build option: define ARB_ROUND_ROBIN_EN to alternate ties; otherwise data side always wins ties.
module cache_bus_arbiter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // I-cache side
    input  logic        i_inst_req,
    input  logic        i_inst_wr,
    input  logic [1:0]  i_inst_size,
    input  logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_wdata,
    output logic [31:0] o_inst_rdata,
    output logic        o_inst_addr_ok,
    output logic        o_inst_data_ok,
    // D-cache side
    input  logic        i_data_req,
    input  logic        i_data_wr,
    input  logic [1:0]  i_data_size,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    output logic [31:0] o_data_rdata,
    output logic        o_data_addr_ok,
    output logic        o_data_data_ok,
    // bridge side
    output logic        o_bus_req,
    output logic        o_bus_wr,
    output logic [1:0]  o_bus_size,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_addr_ok,
    input  logic        i_bus_data_ok,
    output logic        o_arb_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    logic [1:0] r_state;
    logic       r_grant;
    logic       w_winner;
    logic       w_gnt_req;
    logic       w_bus_req;
    logic       w_addr_hs;
    logic       w_done;
    logic       w_mux_wr;
    logic [1:0] w_mux_size;
    logic [31:0] w_mux_addr;
    logic [31:0] w_mux_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // Ties go to whichever master did not win the previous arbitration.
    always_comb begin
        w_winner = GNT_INST;
        if (i_inst_req && i_data_req)
            w_winner = ~r_last_grant;
        else if (i_data_req)
            w_winner = GNT_DATA;
    end

    // Remember the most recent winner; updated only when a grant is issued.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_last_grant <= GNT_INST;
        else if (r_state == S_IDLE && (i_inst_req || i_data_req))
            r_last_grant <= w_winner;
    end
`else
    // Fixed priority: the data side wins whenever it is requesting.
    always_comb begin
        w_winner = i_data_req ? GNT_DATA : GNT_INST;
    end
`endif

    // Request path is a pass-through of the granted master, forced to zero outside the address phase.
    always_comb begin
        w_gnt_req   = (r_grant == GNT_DATA) ? i_data_req   : i_inst_req;
        w_mux_wr    = (r_grant == GNT_DATA) ? i_data_wr    : i_inst_wr;
        w_mux_size  = (r_grant == GNT_DATA) ? i_data_size  : i_inst_size;
        w_mux_addr  = (r_grant == GNT_DATA) ? i_data_addr  : i_inst_addr;
        w_mux_wdata = (r_grant == GNT_DATA) ? i_data_wdata : i_inst_wdata;
        w_bus_req   = (r_state == S_ADDR) && w_gnt_req;
        w_addr_hs   = w_bus_req && i_bus_addr_ok;
        // Completion either in DATA, or in ADDR when the bridge answers both phases at once.
        w_done      = (w_addr_hs && i_bus_data_ok) || ((r_state == S_DATA) && i_bus_data_ok);
    end

    // Drive bus and master response outputs; bridge oks outside their phase never reach a master.
    always_comb begin
        o_bus_req      = w_bus_req;
        o_bus_wr       = w_bus_req & w_mux_wr;
        o_bus_size     = {2{w_bus_req}} & w_mux_size;
        o_bus_addr     = {32{w_bus_req}} & w_mux_addr;
        o_bus_wdata    = {32{w_bus_req}} & w_mux_wdata;
        o_inst_addr_ok = w_addr_hs && (r_grant == GNT_INST);
        o_data_addr_ok = w_addr_hs && (r_grant == GNT_DATA);
        o_inst_data_ok = w_done && (r_grant == GNT_INST);
        o_data_data_ok = w_done && (r_grant == GNT_DATA);
        o_inst_rdata   = i_bus_rdata;
        o_data_rdata   = i_bus_rdata;
        o_arb_busy     = (r_state != S_IDLE);
    end

    // Transaction sequencer: IDLE picks a winner, ADDR waits for acceptance, DATA waits for the response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_grant <= GNT_INST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_inst_req || i_data_req) begin
                        r_grant <= w_winner;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // A withdrawn request abandons the grant before anything reached the bridge.
                    if (!w_gnt_req)
                        r_state <= S_IDLE;
                    else if (i_bus_addr_ok)
                        r_state <= i_bus_data_ok ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (i_bus_data_ok)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Inputs change just after the falling edge; outputs are sampled 1 ns later, well before the rising edge.
// Build with ARB_ROUND_ROBIN_EN defined to check the alternating-tie behaviour instead of fixed priority.
module tb_cache_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, bus_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok, arb_busy;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    // Status snapshot: {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, arb_busy}
    logic [5:0]  st;
    assign st = {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, arb_busy};

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_bus_arbiter dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_inst_req     (inst_req),
        .i_inst_wr      (inst_wr),
        .i_inst_size    (inst_size),
        .i_inst_addr    (inst_addr),
        .i_inst_wdata   (inst_wdata),
        .o_inst_rdata   (inst_rdata),
        .o_inst_addr_ok (inst_addr_ok),
        .o_inst_data_ok (inst_data_ok),
        .i_data_req     (data_req),
        .i_data_wr      (data_wr),
        .i_data_size    (data_size),
        .i_data_addr    (data_addr),
        .i_data_wdata   (data_wdata),
        .o_data_rdata   (data_rdata),
        .o_data_addr_ok (data_addr_ok),
        .o_data_data_ok (data_data_ok),
        .o_bus_req      (bus_req),
        .o_bus_wr       (bus_wr),
        .o_bus_size     (bus_size),
        .o_bus_addr     (bus_addr),
        .o_bus_wdata    (bus_wdata),
        .i_bus_rdata    (bus_rdata),
        .i_bus_addr_ok  (bus_addr_ok),
        .i_bus_data_ok  (bus_data_ok),
        .o_arb_busy     (arb_busy)
    );

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        inst_req = 1; inst_addr = 32'h1111_0000; inst_wdata = 32'h5555_5555; inst_wr = 1; inst_size = 2;
        data_req = 1; data_addr = 32'h2222_0000; data_wdata = 32'hAAAA_AAAA; data_wr = 1; data_size = 2;
        bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h0;
        #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL reset_status got %b exp 000000", st); end
        n_vec++; if ({bus_addr, bus_wdata, bus_wr, bus_size} !== 67'd0) begin n_bad++;
            $display("FAIL reset_bus got addr %h wdata %h wr %b size %b exp all zero", bus_addr, bus_wdata, bus_wr, bus_size); end
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL reset_held got %b exp 000000", st); end
        // Release with only the I-side requesting: first edge after release must arbitrate.
        @(negedge clk);
        rst_n = 1; clear_inputs(); inst_req = 1; inst_addr = 32'h0000_0040;
        #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL release_idle got %b exp 000000", st); end
        @(negedge clk); #1;
        n_vec++; if (st !== 6'b100001 || bus_addr !== 32'h0000_0040) begin n_bad++;
            $display("FAIL first_arb got st %b addr %h exp 100001 addr 00000040", st, bus_addr); end
        @(negedge clk); inst_req = 0; #1;
        n_vec++; if (st !== 6'b000001) begin n_bad++; $display("FAIL first_arb_drop got %b exp 000001", st); end
        @(negedge clk); clear_inputs(); #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL first_arb_idle got %b exp 000000", st); end
    endtask

    task automatic test_single_read();
        @(negedge clk); clear_inputs(); inst_req = 1; inst_addr = 32'hBFC0_0000; #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL single_c0 got %b exp 000000", st); end
        @(negedge clk); bus_addr_ok = 1; #1;
        n_vec++; if (st !== 6'b110001 || bus_addr !== 32'hBFC0_0000 || bus_wr !== 1'b0) begin n_bad++;
            $display("FAIL single_c1 got st %b addr %h wr %b exp 110001 addr bfc00000 wr 0", st, bus_addr, bus_wr); end
        @(negedge clk); inst_req = 0; bus_addr_ok = 0; #1;
        n_vec++; if (st !== 6'b000001) begin n_bad++; $display("FAIL single_c2 got %b exp 000001", st); end
        @(negedge clk); bus_data_ok = 1; bus_rdata = 32'h3C08_0001; #1;
        n_vec++; if (st !== 6'b000101 || inst_rdata !== 32'h3C08_0001) begin n_bad++;
            $display("FAIL single_c3 got st %b rdata %h exp 000101 rdata 3c080001", st, inst_rdata); end
        @(negedge clk); clear_inputs(); #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL single_c4 got %b exp 000000", st); end
    endtask

    task automatic test_priority();
        @(negedge clk); clear_inputs();
        inst_req = 1; inst_addr = 32'h0000_1000;
        data_req = 1; data_wr = 1; data_addr = 32'h0000_2000; data_wdata = 32'hDEAD_BEEF; data_size = 2;
        #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL prio_c0 got %b exp 000000", st); end
        @(negedge clk); bus_addr_ok = 1; #1;
        n_vec++; if (st !== 6'b101001 || bus_addr !== 32'h2000 || bus_wr !== 1'b1 || bus_wdata !== 32'hDEAD_BEEF || bus_size !== 2'd2) begin
            n_bad++; $display("FAIL prio_data_first got st %b addr %h wr %b wdata %h size %0d exp 101001 2000 1 deadbeef 2",
                              st, bus_addr, bus_wr, bus_wdata, bus_size); end
        @(negedge clk); data_req = 0; bus_addr_ok = 0; #1;
        n_vec++; if (st !== 6'b000001) begin n_bad++; $display("FAIL prio_c2 got %b exp 000001", st); end
        @(negedge clk); bus_data_ok = 1; bus_rdata = 32'h0BAD_F00D; #1;
        n_vec++; if (st !== 6'b000011) begin n_bad++; $display("FAIL prio_data_done got %b exp 000011", st); end
        @(negedge clk); bus_data_ok = 0; #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL prio_gap got %b exp 000000", st); end
        @(negedge clk); bus_addr_ok = 1; #1;
        n_vec++; if (st !== 6'b110001 || bus_addr !== 32'h1000 || bus_wr !== 1'b0) begin n_bad++;
            $display("FAIL prio_inst_second got st %b addr %h wr %b exp 110001 1000 0", st, bus_addr, bus_wr); end
        @(negedge clk); inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1234_0000; #1;
        n_vec++; if (st !== 6'b000101 || inst_rdata !== 32'h1234_0000) begin n_bad++;
            $display("FAIL prio_inst_done got st %b rdata %h exp 000101 12340000", st, inst_rdata); end
        @(negedge clk); clear_inputs(); #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL prio_end got %b exp 000000", st); end
    endtask

    // Both sides hold their requests and the bridge completes each in one cycle: 4 grants in 8 cycles.
    task automatic test_tie_order();
        logic [1:0] order [4];   // 1 = inst, 2 = data
`ifdef ARB_ROUND_ROBIN_EN
        order[0] = 2; order[1] = 1; order[2] = 2; order[3] = 1;
`else
        order[0] = 2; order[1] = 2; order[2] = 2; order[3] = 2;
`endif
        @(negedge clk); clear_inputs();
        inst_req = 1; inst_addr = 32'h0000_1000;
        data_req = 1; data_addr = 32'h0000_2000; data_wr = 1; data_wdata = 32'hDEAD_BEEF;
        bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hCAFE_0000;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            n_vec++;
            if (c % 2 == 0) begin
                if (st !== 6'b000000) begin n_bad++; $display("FAIL tie_idle_%0d got %b exp 000000", c, st); end
            end else if (order[c/2] == 2) begin
                if (st !== 6'b101011) begin n_bad++; $display("FAIL tie_grant_%0d got %b exp 101011 (data)", c/2, st); end
            end else begin
                if (st !== 6'b110101) begin n_bad++; $display("FAIL tie_grant_%0d got %b exp 110101 (inst)", c/2, st); end
            end
        end
        @(negedge clk); clear_inputs(); #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL tie_end got %b exp 000000", st); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk); clear_inputs(); data_req = 1; data_wr = 1; data_addr = 32'h0000_3000; #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL same_c0 got %b exp 000000", st); end
        @(negedge clk); bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h1234_5678; #1;
        n_vec++; if (st !== 6'b101011 || data_rdata !== 32'h1234_5678) begin n_bad++;
            $display("FAIL same_both_ok got st %b rdata %h exp 101011 12345678", st, data_rdata); end
        @(negedge clk); clear_inputs(); #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL same_idle_after got %b exp 000000", st); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); clear_inputs(); inst_req = 1; inst_addr = 32'h0000_4000; #1;
        @(negedge clk); bus_addr_ok = 1; #1;
        n_vec++; if (st !== 6'b110001) begin n_bad++; $display("FAIL rstmid_addr got %b exp 110001", st); end
        @(negedge clk); inst_req = 0; bus_addr_ok = 0; #1;
        n_vec++; if (st !== 6'b000001) begin n_bad++; $display("FAIL rstmid_data got %b exp 000001", st); end
        #2 rst_n = 0;
        #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL rstmid_async got %b exp 000000", st); end
        @(negedge clk); rst_n = 1; bus_data_ok = 1; bus_rdata = 32'h7777_7777; #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL rstmid_late_ok got %b exp 000000", st); end
        @(negedge clk); #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL rstmid_late_ok2 got %b exp 000000", st); end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_req_drop();
        @(negedge clk); clear_inputs(); data_req = 1; data_addr = 32'h0000_5000; #1;
        @(negedge clk); #1;
        n_vec++; if (st !== 6'b100001) begin n_bad++; $display("FAIL drop_addr got %b exp 100001", st); end
        @(negedge clk); data_req = 0; bus_addr_ok = 1; #1;
        n_vec++; if (st !== 6'b000001 || bus_addr !== 32'd0) begin n_bad++;
            $display("FAIL drop_withdrawn got st %b addr %h exp 000001 0", st, bus_addr); end
        @(negedge clk); bus_addr_ok = 0; bus_data_ok = 1; #1;
        n_vec++; if (st !== 6'b000000) begin n_bad++; $display("FAIL drop_idle got %b exp 000000", st); end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_spurious();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); clear_inputs();
            inst_addr = 32'hFFFF_FFFF; inst_wdata = 32'hFFFF_FFFF; inst_wr = 1; inst_size = 3;
            bus_addr_ok = 1; bus_data_ok = (c != 1); #1;
            n_vec++; if (st !== 6'b000000 || bus_addr !== 32'd0 || bus_wdata !== 32'd0 || bus_wr !== 1'b0 || bus_size !== 2'd0) begin
                n_bad++; $display("FAIL spurious_%0d got st %b addr %h wdata %h exp 000000 and zero bus", c, st, bus_addr, bus_wdata); end
        end
        @(negedge clk); clear_inputs();
    endtask

    // Randomized masters and bridge. The model tracks which master owns the bus and whether its address
    // was accepted; a new owner is chosen by the tie rule from requests seen in the preceding idle cycle.
    task automatic test_random();
        bit          pend [1:2], acc [1:2];
        int          gap [1:2];
        logic [31:0] m_addr [1:2], m_wdata [1:2];
        logic        m_wr [1:2];
        logic [1:0]  m_size [1:2];
        int          owner, last_g, done_cnt;
        bit          accepted, br_busy, prev_p1, prev_p2, prev_done;
        bit          e_req, e_aok, e_dok;
        logic [31:0] e_addr, e_wdata;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [5:0]  e_st;
        owner = 0; last_g = 1; done_cnt = 0; accepted = 0; br_busy = 0;
        prev_p1 = 0; prev_p2 = 0; prev_done = 0;
        for (int m = 1; m <= 2; m++) begin pend[m] = 0; acc[m] = 0; gap[m] = 0; end
        @(negedge clk); clear_inputs(); rst_n = 0;
        @(negedge clk); rst_n = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int m = 1; m <= 2; m++) begin
                if (!pend[m]) begin
                    if (gap[m] > 0) gap[m]--;
                    else if ($urandom_range(0, 2) == 0) begin
                        pend[m] = 1; acc[m] = 0;
                        m_addr[m] = $urandom; m_wdata[m] = $urandom;
                        m_wr[m] = 1'($urandom_range(0, 1)); m_size[m] = 2'($urandom_range(0, 2));
                    end
                end
            end
            inst_req = pend[1] && !acc[1]; inst_addr = m_addr[1]; inst_wdata = m_wdata[1];
            inst_wr = m_wr[1]; inst_size = m_size[1];
            data_req = pend[2] && !acc[2]; data_addr = m_addr[2]; data_wdata = m_wdata[2];
            data_wr = m_wr[2]; data_size = m_size[2];
            bus_addr_ok = 1'($urandom_range(0, 1));
            bus_data_ok = br_busy ? ($urandom_range(0, 2) == 0) : (bus_addr_ok && $urandom_range(0, 3) == 0);
            bus_rdata = $urandom;
            #1;
            if (owner == 0 && (prev_p1 || prev_p2) && !prev_done) begin
                if (prev_p1 && prev_p2) begin
`ifdef ARB_ROUND_ROBIN_EN
                    owner = (last_g == 1) ? 2 : 1;
`else
                    owner = 2;
`endif
                end else owner = prev_p2 ? 2 : 1;
                last_g = owner; accepted = 0;
            end
            e_req = (owner != 0) && !accepted;
            e_aok = e_req && bus_addr_ok;
            e_dok = (owner != 0) && (accepted ? bus_data_ok : (bus_addr_ok && bus_data_ok));
            e_addr = e_req ? m_addr[owner] : 32'd0;
            e_wdata = e_req ? m_wdata[owner] : 32'd0;
            e_wr = e_req ? m_wr[owner] : 1'b0;
            e_size = e_req ? m_size[owner] : 2'd0;
            e_st = {e_req, e_aok && owner == 1, e_aok && owner == 2, e_dok && owner == 1, e_dok && owner == 2, owner != 0};
            n_vec++;
            if (st !== e_st) begin n_bad++; $display("FAIL rand_status cyc %0d got %b exp %b", cyc, st, e_st); end
            if ({bus_addr, bus_wdata, bus_wr, bus_size} !== {e_addr, e_wdata, e_wr, e_size}) begin n_bad++;
                $display("FAIL rand_bus cyc %0d got %h/%h/%b/%0d exp %h/%h/%b/%0d", cyc,
                         bus_addr, bus_wdata, bus_wr, bus_size, e_addr, e_wdata, e_wr, e_size); end
            if (e_dok && ((owner == 1 && inst_rdata !== bus_rdata) || (owner == 2 && data_rdata !== bus_rdata))) begin
                n_bad++; $display("FAIL rand_rdata cyc %0d got %h/%h exp %h", cyc, inst_rdata, data_rdata, bus_rdata); end
            prev_p1 = inst_req; prev_p2 = data_req; prev_done = e_dok;
            if (e_aok) begin accepted = 1; acc[owner] = 1; br_busy = !bus_data_ok; end
            if (e_dok) begin
                pend[owner] = 0; acc[owner] = 0; gap[owner] = $urandom_range(0, 3);
                owner = 0; accepted = 0; br_busy = 0; done_cnt++;
            end
        end
        n_vec++;
        if (done_cnt < 100) begin n_bad++; $display("FAIL rand_throughput got %0d completions exp at least 100", done_cnt); end
        @(negedge clk); clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_priority();
        test_tie_order();
        test_same_cycle();
        test_reset_mid();
        test_req_drop();
        test_spurious();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 Parameters SHALL be: none; all widths are fixed (addr/data 32, size 2).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 inst_req/inst_wr/inst_size/inst_addr/inst_wdata  in  1/1/2/32/32  SRAM-like request from I-cache miss side.
REQ-005 inst_rdata/inst_addr_ok/inst_data_ok  out  32/1/1  response to I-cache.
REQ-006 data_req/data_wr/data_size/data_addr/data_wdata  in  1/1/2/32/32  SRAM-like request from D-cache miss side.
REQ-007 data_rdata/data_addr_ok/data_data_ok  out  32/1/1  response to D-cache.
REQ-008 bus_req/bus_wr/bus_size/bus_addr/bus_wdata  out  1/1/2/32/32  merged request to SRAM-to-AXI bridge.
REQ-009 bus_rdata/bus_addr_ok/bus_data_ok  in  32/1/1  bridge response.
REQ-010 arb_busy  out  1  high in every state except IDLE.

Function
REQ-011 FSM states SHALL be IDLE, ADDR, DATA; one transaction outstanding at most.
REQ-012 IDLE: bus_req=0; if inst_req|data_req, latch winner into grant register and go to ADDR next cycle (request-to-bus_req latency 1 cycle).
REQ-013 Without ARB_ROUND_ROBIN_EN, when both request in IDLE the data side SHALL win.
REQ-014 ADDR: bus_req/wr/size/addr/wdata SHALL equal the granted master's inputs (pass-through); non-granted addr_ok=0.
REQ-015 ADDR: granted addr_ok SHALL equal bus_addr_ok; on bus_addr_ok=1 go to DATA.
REQ-016 ADDR: if granted req drops before bus_addr_ok, return to IDLE with no transaction issued.
REQ-017 DATA: bus_req=0; on bus_data_ok=1 pulse granted data_ok for that cycle, then IDLE.
REQ-018 bus_addr_ok and bus_data_ok both high in ADDR SHALL complete the transaction: addr_ok and data_ok pulse same cycle, next state IDLE.
REQ-019 inst_rdata and data_rdata SHALL both equal bus_rdata; only data_ok qualifies them.
REQ-020 bus_addr_ok in IDLE/DATA and bus_data_ok in IDLE SHALL be ignored; all master ok outputs 0.
REQ-021 A request held in IDLE after completion SHALL be re-arbitrated; minimum spacing between two bus_req assertions is 1 idle cycle.
REQ-022 bus_* outputs SHALL be 0 whenever bus_req=0.

Reset
REQ-023 On rst=0: state=IDLE, grant=none, last-grant=inst, all outputs 0, arb_busy=0, asynchronously.
REQ-024 Reset mid-transaction SHALL abandon it; no data_ok is issued for it after release.
REQ-025 First arbitration SHALL occur on the first rising edge with rst=1.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN defined: ties go to the master not granted last; last-grant updates on each ADDR entry.
REQ-027 Macro absent: fixed data-over-inst priority; last-grant register not implemented.

Verification
REQ-028 Single inst read addr 0xBFC00000: inst_req cycle 0 -> bus_req cycle 1, bus_addr_ok cycle 1, bus_data_ok cycle 3 rdata 0x3C080001 -> inst_data_ok cycle 3, inst_rdata 0x3C080001.
REQ-029 Both request cycle 0 (inst 0x1000, data write 0x2000 wdata 0xDEADBEEF), no macro -> bus_addr 0x2000 bus_wr=1 first; inst served second; inst_addr_ok=0 throughout data txn.
REQ-030 Same stimulus with ARB_ROUND_ROBIN_EN, held for 4 transactions -> grant order data, inst, data, inst.
REQ-031 bus_addr_ok and bus_data_ok same cycle in ADDR -> addr_ok and data_ok pulse together, arb_busy=0 next cycle.
REQ-032 rst=0 asserted in DATA, bus_data_ok pulses after release -> no master data_ok, bus_req=0, state IDLE.
REQ-033 data_req drops in ADDR before bus_addr_ok -> bus_req=0 next cycle, no data_ok, state IDLE.
